// File: rtl/reg_file_rw_if.sv
// reg_file_rw_if: register file access bus; debug read pair present only with REG_FILE_DEBUG_EN
interface reg_file_rw_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic              reg_we;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
`ifdef REG_FILE_DEBUG_EN
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
`endif
  modport master (
    output reg_we, rs_addr, rt_addr, rd_addr, wdata,
    input  rs_data, rt_data
`ifdef REG_FILE_DEBUG_EN
    , output dbg_addr, input dbg_data
`endif
  );
  modport slave (
    input  reg_we, rs_addr, rt_addr, rd_addr, wdata,
    output rs_data, rt_data
`ifdef REG_FILE_DEBUG_EN
    , input dbg_addr, output dbg_data
`endif
  );
endinterface

// File: rtl/reg_file_rw.sv
// reg_file_rw: MIPS 32x32 register file, 2 comb read ports with write bypass; debug port under REG_FILE_DEBUG_EN
module reg_file_rw #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_3FFC,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h0000_1800
) (
  input logic          clk,
  input logic          rst,
  reg_file_rw_if.slave bus
);
  localparam int N = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [N];
  logic              wr;
  assign wr = !rst && bus.reg_we && bus.rd_addr != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        regs[i] <= i == 28 ? GP_INIT : i == 29 ? SP_INIT : '0;
    end else if (wr) begin
      regs[bus.rd_addr] <= bus.wdata;
    end
  end
  always_comb begin
    bus.rs_data = wr && bus.rd_addr == bus.rs_addr ? bus.wdata : bus.rs_addr == '0 ? '0 : regs[bus.rs_addr];
    bus.rt_data = wr && bus.rd_addr == bus.rt_addr ? bus.wdata : bus.rt_addr == '0 ? '0 : regs[bus.rt_addr];
  end
`ifdef REG_FILE_DEBUG_EN
  // committed state only: the debug view never sees the in-flight write
  assign bus.dbg_data = bus.dbg_addr == '0 ? '0 : regs[bus.dbg_addr];
`endif
endmodule
